// File: rtl/expr_seq_ctrl.sv
// Multi-cycle evaluator of q = ((a - b)*(3c + 1) - 4d) >>> 1 using one shared adder and one multiplier.
// Optional overflow detection is built when EXPR_SEQ_OVF_EN is defined.
module expr_seq_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] c_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  q_valid_o,
    input  logic                  q_ready_i,
    output logic                  busy_o,
    output logic                  ovf_o
);

    typedef enum logic [2:0] {IDLE, S_AB, S_C3, S_C1, S_MUL, S_D, S_OUT} state_t;

    localparam logic signed [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);
    localparam logic signed [DATA_WIDTH-1:0] THREE = DATA_WIDTH'(3);

    state_t state, state_nxt;
    logic   accept;

    logic signed [DATA_WIDTH-1:0] a_r, b_r, c_r, d_r, r0, r1, q_r;
    logic signed [DATA_WIDTH-1:0] add_x, add_y, add_res, mul_x, mul_y, mul_res, d4;
    logic                         add_sub;

    function automatic logic signed [DATA_WIDTH-1:0] asr1(input logic signed [DATA_WIDTH-1:0] x);
        return x >>> 1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (srst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus operand selection for the shared adder and multiplier.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        add_x     = '0;
        add_y     = '0;
        add_sub   = 1'b0;
        mul_x     = '0;
        mul_y     = '0;
        case (state)
            IDLE: begin
                if (in_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = S_AB;
                end
            end
            S_AB: begin
                add_x     = a_r;
                add_y     = b_r;
                add_sub   = 1'b1;
                state_nxt = S_C3;
            end
            S_C3: begin
                mul_x     = c_r;
                mul_y     = THREE;
                state_nxt = S_C1;
            end
            S_C1: begin
                add_x     = r1;
                add_y     = ONE;
                state_nxt = S_MUL;
            end
            S_MUL: begin
                mul_x     = r0;
                mul_y     = r1;
                state_nxt = S_D;
            end
            S_D: begin
                add_x     = r0;
                add_y     = d4;
                add_sub   = 1'b1;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (q_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign d4 = d_r <<< 2;

`ifdef EXPR_SEQ_OVF_EN
    logic [DATA_WIDTH:0]     add_ext;
    logic [2*DATA_WIDTH-1:0] mul_full;
    logic                    add_ovf, mul_ovf, d4_ovf, ovf_sticky, ovf_r;

    // One guard bit on the adder and a double-width product expose signed overflow.
    assign add_ext  = add_sub ? ({add_x[DATA_WIDTH-1], add_x} - {add_y[DATA_WIDTH-1], add_y})
                              : ({add_x[DATA_WIDTH-1], add_x} + {add_y[DATA_WIDTH-1], add_y});
    assign add_res  = add_ext[DATA_WIDTH-1:0];
    assign add_ovf  = add_ext[DATA_WIDTH] ^ add_ext[DATA_WIDTH-1];
    assign mul_full = $signed({{DATA_WIDTH{mul_x[DATA_WIDTH-1]}}, mul_x})
                    * $signed({{DATA_WIDTH{mul_y[DATA_WIDTH-1]}}, mul_y});
    assign mul_res  = mul_full[DATA_WIDTH-1:0];
    assign mul_ovf  = ~((&mul_full[2*DATA_WIDTH-1:DATA_WIDTH-1]) | ~(|mul_full[2*DATA_WIDTH-1:DATA_WIDTH-1]));
    assign d4_ovf   = ~((&d_r[DATA_WIDTH-1:DATA_WIDTH-3]) | ~(|d_r[DATA_WIDTH-1:DATA_WIDTH-3]));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ovf_sticky <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (accept) begin
            ovf_sticky <= 1'b0;
        end else if (state == S_AB || state == S_C1) begin
            ovf_sticky <= ovf_sticky | add_ovf;
        end else if (state == S_C3 || state == S_MUL) begin
            ovf_sticky <= ovf_sticky | mul_ovf;
        end else if (state == S_D) begin
            ovf_r <= ovf_sticky | add_ovf | d4_ovf;
        end
    end

    assign ovf_o = ovf_r;
`else
    assign add_res = add_sub ? (add_x - add_y) : (add_x + add_y);
    assign mul_res = mul_x * mul_y;
    assign ovf_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
            d_r <= '0;
            r0  <= '0;
            r1  <= '0;
            q_r <= '0;
        end else begin
            if (accept) begin
                a_r <= a_i;
                b_r <= b_i;
                c_r <= c_i;
                d_r <= d_i;
            end
            case (state)
                S_AB:    r0  <= add_res;
                S_C3:    r1  <= mul_res;
                S_C1:    r1  <= add_res;
                S_MUL:   r0  <= mul_res;
                S_D:     q_r <= asr1(add_res);
                default: ;
            endcase
        end
    end

    assign in_ready_o = (state == IDLE);
    assign busy_o     = (state != IDLE);
    assign q_valid_o  = (state == S_OUT);
    assign q_o        = q_r;

endmodule

// File: tb/tb_expr_seq_ctrl.sv
// Bench for expr_seq_ctrl: directed steps plus random operand sets checked against an arithmetic model.
module tb_expr_seq_ctrl;

    logic        clk = 1'b0;
    logic        srst_i = 1'b1;
    logic [31:0] a_i = '0, b_i = '0, c_i = '0, d_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] q_o;
    logic        q_valid_o;
    logic        q_ready_i = 1'b0;
    logic        busy_o;
    logic        ovf_o;

    int passed = 0;
    int total  = 0;

    expr_seq_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i(clk), .srst_i(srst_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .q_o(q_o), .q_valid_o(q_valid_o), .q_ready_i(q_ready_i),
        .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    function automatic int ref_q(input int a, input int b, input int c, input int d);
        int t;
        t = (a - b) * (3 * c + 1) - 4 * d;
        return t >>> 1;
    endfunction

    function automatic bit out_of_range(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    function automatic bit ref_ovf(input int a, input int b, input int c, input int d);
`ifdef EXPR_SEQ_OVF_EN
        longint ab, c3, p1, pr, d4, f;
        bit o;
        ab = longint'(a) - longint'(b);
        c3 = 3 * longint'(c);
        p1 = longint'(int'(c3)) + 1;
        pr = longint'(int'(ab)) * longint'(int'(p1));
        d4 = 4 * longint'(d);
        f  = longint'(int'(pr)) - longint'(int'(d4));
        o  = out_of_range(ab) | out_of_range(c3) | out_of_range(p1)
           | out_of_range(pr) | out_of_range(d4) | out_of_range(f);
        return o;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept one set, walk the fixed latency, hold the result for bp cycles, then consume it.
    task automatic run_op(input string tag, input int a, input int b, input int c, input int d, input int bp);
        int qv;
        int nz;
        qv = ref_q(a, b, c, d);
        a_i = a; b_i = b; c_i = c; d_i = d;
        in_valid_i = 1'b1;
        check({tag, "_rdy_pre"}, 32'(in_ready_o), 32'd1);
        step();
        in_valid_i = 1'b0;
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        check({tag, "_rdy_busy"}, 32'(in_ready_o), 32'd0);
        nz = 0;
        repeat (4) begin
            step();
            if (q_valid_o !== 1'b0) nz++;
        end
        check({tag, "_early_valid"}, 32'(nz), 32'd0);
        step();
        check({tag, "_valid"}, 32'(q_valid_o), 32'd1);
        check({tag, "_q"}, q_o, qv);
        check({tag, "_ovf"}, 32'(ovf_o), 32'(ref_ovf(a, b, c, d)));
        nz = 0;
        repeat (bp) begin
            step();
            if (q_valid_o !== 1'b1 || q_o !== qv || busy_o !== 1'b1) nz++;
        end
        check({tag, "_hold"}, 32'(nz), 32'd0);
        q_ready_i = 1'b1;
        step();
        q_ready_i = 1'b0;
        check({tag, "_cons_valid"}, 32'(q_valid_o), 32'd0);
        check({tag, "_cons_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_cons_rdy"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        int acc[$];
        int res[$];
        int bad;
        int ra, rb, rc, rd;

        // Reset state
        step();
        step();
        check("rst_rdy", 32'(in_ready_o), 32'd1);
        check("rst_valid", 32'(q_valid_o), 32'd0);
        check("rst_q", q_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        srst_i = 1'b0;
        step();

        // Directed cases
        run_op("basic", 10, 4, 2, 3, 0);
        check("basic_const", q_o, 32'd15);
        run_op("neg", 1, 5, 1, 0, 1);
        check("neg_const", q_o, 32'hFFFF_FFF8);
        run_op("round", 3, 2, 0, 1, 0);
        check("round_const", q_o, 32'hFFFF_FFFE);
        run_op("ovf", 32'h7FFF_FFFF, -1, 0, 0, 0);
        check("ovf_const", q_o, 32'hC000_0000);
`ifdef EXPR_SEQ_OVF_EN
        check("ovf_flag", 32'(ovf_o), 32'd1);
`else
        check("ovf_flag", 32'(ovf_o), 32'd0);
`endif

        // Backpressure: new operands offered while the result waits
        a_i = 7; b_i = 2; c_i = 1; d_i = 1;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        repeat (5) step();
        check("bp_valid", 32'(q_valid_o), 32'd1);
        check("bp_q", q_o, ref_q(7, 2, 1, 1));
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            if (i < 2) begin a_i = 100; b_i = 1; c_i = 5; d_i = 9; end
            else       begin a_i = -20; b_i = 3; c_i = 4; d_i = -2; end
            step();
            if (q_valid_o !== 1'b1 || q_o !== ref_q(7, 2, 1, 1) || in_ready_o !== 1'b0) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        q_ready_i = 1'b1;
        step();
        q_ready_i = 1'b0;
        check("bp_cons_rdy", 32'(in_ready_o), 32'd1);
        step();
        in_valid_i = 1'b0;
        repeat (5) step();
        check("bp_next_valid", 32'(q_valid_o), 32'd1);
        check("bp_next_q", q_o, ref_q(-20, 3, 4, -2));
        q_ready_i = 1'b1;
        step();
        q_ready_i = 1'b0;

        // Reset while in S_MUL
        a_i = 9; b_i = 1; c_i = 3; d_i = 2;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        repeat (3) step();
        srst_i = 1'b1;
        step();
        srst_i = 1'b0;
        check("mrst_rdy", 32'(in_ready_o), 32'd1);
        check("mrst_valid", 32'(q_valid_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        bad = 0;
        repeat (8) begin
            step();
            if (q_valid_o !== 1'b0) bad++;
        end
        check("mrst_no_result", 32'(bad), 32'd0);
        run_op("after_rst", -6, 11, -2, 5, 0);

        // Back-to-back with ready held high
        q_ready_i = 1'b1;
        a_i = 12; b_i = -3; c_i = 2; d_i = 4;
        in_valid_i = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (in_ready_o && in_valid_i) acc.push_back(cyc);
            step();
            if (acc.size() == 1) begin a_i = -50; b_i = 8; c_i = -7; d_i = -1; end
            if (acc.size() == 2) in_valid_i = 1'b0;
            if (q_valid_o) res.push_back(int'(q_o));
        end
        in_valid_i = 1'b0;
        q_ready_i = 1'b0;
        check("b2b_acc_n", 32'(acc.size()), 32'd2);
        check("b2b_gap", (acc.size() == 2) ? 32'(acc[1] - acc[0]) : 32'hFFFF_FFFF, 32'd7);
        check("b2b_res_n", 32'(res.size()), 32'd2);
        check("b2b_q0", (res.size() > 0) ? res[0] : 32'hx, ref_q(12, -3, 2, 4));
        check("b2b_q1", (res.size() > 1) ? res[1] : 32'hx, ref_q(-50, 8, -7, -1));

        // Random operand sets
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                ra = int'($urandom_range(0, 200)) - 100;
                rb = int'($urandom_range(0, 200)) - 100;
                rc = int'($urandom_range(0, 200)) - 100;
                rd = int'($urandom_range(0, 200)) - 100;
            end else begin
                ra = int'($urandom); rb = int'($urandom);
                rc = int'($urandom); rd = int'($urandom);
            end
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rd, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/expr_seq_ctrl.md
# expr_seq_ctrl

Multi-cycle sequencer that evaluates q = ((a − b)·(3c + 1) − 4d) >>> 1 with one shared adder/subtractor and one shared multiplier, driven by a state machine. It replaces the fully pipelined evaluator in area-constrained builds. Operands arrive over a valid/ready handshake and results leave over one too.

## Interface
- DATA_WIDTH, 32, width of operands, intermediates and result (signed two's complement)

- clk_i  in  1  clock, all logic on rising edge
- srst_i  in  1  reset, synchronous, active-high
- a_i, b_i, c_i, d_i  in  DATA_WIDTH each  signed operands
- in_valid_i  in  1  operand set valid
- in_ready_o  out  1  block can accept an operand set
- q_o  out  DATA_WIDTH  signed result
- q_valid_o  out  1  result valid
- q_ready_i  in  1  downstream accepts result
- busy_o  out  1  computation in progress (state ≠ IDLE)
- ovf_o  out  1  overflow flag, qualified by q_valid_o

## Operation
- States: IDLE, S_AB, S_C3, S_C1, S_MUL, S_D, S_OUT.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o, latch a/b/c/d into operand registers and go to S_AB. Operands are not sampled again until the next acceptance.
- S_AB: r0 <= a − b (adder), then S_C3.
- S_C3: r1 <= 3·c (multiplier), then S_C1.
- S_C1: r1 <= r1 + 1 (adder), then S_MUL.
- S_MUL: r0 <= r0·r1 (multiplier), then S_D.
- S_D: q_o <= (r0 − (d << 2)) >>> 1 (adder plus arithmetic shift); q_valid_o <= 1; go to S_OUT.
- S_OUT: hold q_o, q_valid_o and ovf_o stable. On q_ready_i, clear q_valid_o and go to IDLE.
- in_ready_o = (state == IDLE) only. in_valid_i in any other state is ignored and not latched.
- busy_o = (state ≠ IDLE), including S_OUT.
- Arithmetic wraps modulo 2^DATA_WIDTH. The multiplier keeps the low DATA_WIDTH bits. The final shift is arithmetic, so it rounds toward −∞.
- Exactly one adder and one multiplier instance. Operand muxes are selected by state.

## Timing
- Reset values: in_ready_o=1 (state IDLE), q_valid_o=0, q_o=0, busy_o=0, ovf_o=0. All internal registers are 0.
- srst_i has priority in any state, including mid-computation and S_OUT. The in-flight operation is discarded, no result is emitted, and the block is in IDLE on the cycle after the reset edge.
- Latency: acceptance at edge E0 gives q_valid_o=1 after edge E5 (5 cycles).
- Result consumed at edge Ek (q_valid_o & q_ready_i) returns the block to IDLE after Ek. The next acceptance is possible at Ek+1.
- Minimum initiation interval is 7 cycles when q_ready_i is held high.
- q_ready_i may be high before q_valid_o; it has no effect outside S_OUT.
- No combinational path from in_valid_i or q_ready_i to any output.

## Configuration
- EXPR_SEQ_OVF_EN defined:
  - A sticky internal overflow bit is cleared at acceptance.
  - It is set when any step overflows signed DATA_WIDTH: a−b; 3c; +1; the product; 4d, when d is outside [−2^(DATA_WIDTH−3), 2^(DATA_WIDTH−3)−1]; or the final subtract.
  - It is registered to ovf_o together with q_valid_o in S_D.
- EXPR_SEQ_OVF_EN undefined: ovf_o is tied to 0 and no detection logic is built. q_o is identical in both builds.

## Test plan
- Basic (DATA_WIDTH=32): a=10, b=4, c=2, d=3, accepted at E0 → q_valid_o after E5, q_o=15, ovf_o=0, busy_o high from E0 to consumption.
- Negatives and rounding:
  - a=1, b=5, c=1, d=0 → q_o=−8.
  - a=3, b=2, c=0, d=1 → q_o=−2 (−3 >>> 1).
- Backpressure: q_ready_i low for 4 cycles after q_valid_o, new operands driven with in_valid_i=1 →
  - q_o and q_valid_o stay stable and in_ready_o stays 0.
  - The new operands are not latched; the set is accepted only after the result is consumed.
- Overflow: a=32'h7FFF_FFFF, b=−1, c=0, d=0 → q_o=32'hC000_0000; ovf_o=1 with EXPR_SEQ_OVF_EN, 0 without.
- Reset mid-op: srst_i pulsed one cycle while in S_MUL → next cycle in_ready_o=1, q_valid_o=0, busy_o=0, and no result is ever emitted for that set. The following operand set computes correctly.
- Back-to-back: in_valid_i held high with two operand sets, q_ready_i=1 → acceptances exactly 7 cycles apart and both results correct, in order.
